// File: rtl/data_mem_responder.sv
// Memory-mapped data responder: 60-word RAM, console TX byte FIFO, status,
// free-running cycle counter and a read-only ID register behind one 8-bit byte address.
module data_mem_responder #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] ID_VALUE   = 32'h4D495053
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_enable,
    input  logic [7:0]  i_mem_read_address,
    input  logic [7:0]  i_mem_write_address,
    input  logic [31:0] i_mem_write_data,
    input  logic        i_mem_write_enable,
    output logic [31:0] o_mem_read_data,
    output logic [7:0]  o_console_data,
    output logic        o_console_valid,
    input  logic        i_console_ready
);

    localparam int unsigned RAM_WORDS = 60;
    localparam int unsigned PTR_W     = (FIFO_DEPTH > 2) ? 2 : 1;
    localparam int unsigned CNT_W     = 3;
    localparam logic [5:0]  IDX_TX     = 6'd60;
    localparam logic [5:0]  IDX_STATUS = 6'd61;
    localparam logic [5:0]  IDX_CYCLE  = 6'd62;

    // RAM is not on the reset net; it only holds its power-up zero contents.
    logic [31:0] ram_q [RAM_WORDS] = '{default: 32'h0};

    logic [7:0]       fifo_q [FIFO_DEPTH];
    logic [7:0]       fifo_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [31:0]      cycle_q, cycle_d;

    logic [5:0] rd_idx_c;
    logic [5:0] wr_idx_c;
    logic       empty_c;
    logic       full_c;
    logic       push_c;
    logic       drop_c;
    logic       pop_c;
    logic       unused_c;

    assign rd_idx_c = i_mem_read_address[7:2];
    assign wr_idx_c = i_mem_write_address[7:2];
    assign empty_c  = (count_q == CNT_W'(0));
    assign full_c   = (count_q == CNT_W'(FIFO_DEPTH));
    assign unused_c = ^{i_mem_read_address[1:0], i_mem_write_address[1:0]};

    // Fullness uses the pre-edge count, so a pop never makes room for a same-edge push.
    assign push_c = i_mem_write_enable && (wr_idx_c == IDX_TX) && !full_c;
    assign drop_c = i_mem_write_enable && (wr_idx_c == IDX_TX) && full_c;
    assign pop_c  = !empty_c && i_console_ready;

    assign o_console_valid = !empty_c;
    assign o_console_data  = empty_c ? 8'h00 : fifo_q[rd_ptr_q];

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        ovf_d    = ovf_q;
        cycle_d  = cycle_q + 32'd1;
        if (push_c) begin
            fifo_d[wr_ptr_q] = i_mem_write_data[7:0];
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (drop_c) begin
            ovf_d = 1'b1;
        end else if (i_mem_write_enable && (wr_idx_c == IDX_STATUS) && i_mem_write_data[2]) begin
            ovf_d = 1'b0;
        end
        if (i_mem_write_enable && (wr_idx_c == IDX_CYCLE)) begin
            cycle_d = i_mem_write_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q   <= '{default: 8'h00};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            cycle_q  <= 32'h0;
        end else if (clk_enable) begin
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            cycle_q  <= cycle_d;
        end
    end

    always_ff @(posedge clk) begin
        if (clk_enable && i_mem_write_enable && (wr_idx_c < 6'(RAM_WORDS))) begin
            ram_q[wr_idx_c] <= i_mem_write_data;
        end
    end

    // Read path is purely combinational; same-edge writes are seen only after the edge.
    always_comb begin
        o_mem_read_data = 32'h0;
        case (rd_idx_c)
            IDX_TX:     o_mem_read_data = 32'h0;
            IDX_STATUS: o_mem_read_data = {26'h0, count_q, ovf_q, full_c, empty_c};
            IDX_CYCLE:  o_mem_read_data = cycle_q;
            6'd63:      o_mem_read_data = ID_VALUE;
            default:    o_mem_read_data = ram_q[rd_idx_c];
        endcase
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with a byte scoreboard for the console FIFO.
module tb_data_mem_responder;

    logic        clk;
    logic        rst_n;
    logic        clk_enable;
    logic [7:0]  raddr;
    logic [7:0]  waddr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic [7:0]  cdata;
    logic        cvalid;
    logic        cready;

    int n_checks = 0;
    int n_fail   = 0;
    int mcnt     = 0;
    logic [7:0] sb[$];

    data_mem_responder dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .clk_enable          (clk_enable),
        .i_mem_read_address  (raddr),
        .i_mem_write_address (waddr),
        .i_mem_write_data    (wdata),
        .i_mem_write_enable  (we),
        .o_mem_read_data     (rdata),
        .o_console_data      (cdata),
        .o_console_valid     (cvalid),
        .i_console_ready     (cready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        waddr = a;
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
        #1;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
        raddr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    // Console push with cready=0: model accepts up to 4 bytes, otherwise flags overflow.
    task automatic push(input logic [7:0] b);
        if (mcnt < 4) begin
            sb.push_back(b);
            mcnt++;
        end
        wr(8'hF0, {24'h0, b});
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        cready = 1'b1;
        while (sb.size() > 0 && budget < 20) begin
            chk("drain_valid", 32'(cvalid), 32'd1);
            chk("drain_byte", 32'(cdata), 32'(sb.pop_front()));
            budget++;
            tick();
        end
        chk("drain_done", 32'(sb.size()), 32'd0);
        chk("drain_empty_valid", 32'(cvalid), 32'd0);
        mcnt = 0;
    endtask

    initial begin
        rst_n = 1'b0; clk_enable = 1'b1; raddr = 8'h0; waddr = 8'h0;
        wdata = 32'h0; we = 1'b0; cready = 1'b0;
        #1;
        chk("rst_valid", 32'(cvalid), 32'd0);
        chk("rst_data", 32'(cdata), 32'd0);
        rd_chk("ram_powerup", 8'h10, 32'h0);
        rd_chk("rst_cycle", 8'hF8, 32'h0);
        tick(); tick();
        chk("rst_cycle_held", rdata, 32'h0);
        rd_chk("rst_status", 8'hF4, 32'h01);
        #2 rst_n = 1'b1;
        tick();

        // RAM write/read, sub-word address aliasing and read-before-write
        waddr = 8'h10; wdata = 32'h12345678; we = 1'b1; raddr = 8'h13;
        #1 chk("ram_pre_write", rdata, 32'h0);
        tick(); we = 1'b0;
        #1 chk("ram_alias_13", rdata, 32'h12345678);
        waddr = 8'h10; wdata = 32'hAAAA5555; we = 1'b1; raddr = 8'h10;
        #1 chk("raw_old", rdata, 32'h12345678);
        tick(); we = 1'b0;
        #1 chk("raw_new", rdata, 32'hAAAA5555);
        wr(8'hEC, 32'hCAFEF00D);
        rd_chk("ram_last_word", 8'hEF, 32'hCAFEF00D);
        clk_enable = 1'b0;
        wr(8'h20, 32'hDEADBEEF);
        clk_enable = 1'b1;
        rd_chk("ram_write_disabled", 8'h20, 32'h0);
        wr(8'h10, 32'h12345678);

        // Fill FIFO, overflow, W1C clear
        cready = 1'b0;
        push(8'h41); push(8'h42); push(8'h43); push(8'h44);
        rd_chk("status_full", 8'hF4, 32'h22);
        push(8'h45);
        rd_chk("status_ovf", 8'hF4, 32'h26);
        chk("head_hold_valid", 32'(cvalid), 32'd1);
        chk("head_hold_data", 32'(cdata), 32'h41);
        rd_chk("console_read_zero", 8'hF0, 32'h0);
        wr(8'hF4, 32'h4);
        rd_chk("status_w1c", 8'hF4, 32'h22);
        drain();
        rd_chk("status_drained", 8'hF4, 32'h01);

        // Simultaneous push and pop with one byte queued
        cready = 1'b0;
        push(8'h50);
        waddr = 8'hF0; wdata = 32'h51; we = 1'b1; cready = 1'b1;
        #1 chk("pp_head", 32'(cdata), 32'(sb.pop_front()));
        sb.push_back(8'h51);
        tick(); we = 1'b0; cready = 1'b0;
        rd_chk("pp_status", 8'hF4, 32'h08);
        chk("pp_new_head", 32'(cdata), 32'h51);

        // Push at full with a same-edge pop is still dropped
        push(8'h52); push(8'h53); push(8'h54);
        rd_chk("full_again", 8'hF4, 32'h22);
        waddr = 8'hF0; wdata = 32'h99; we = 1'b1; cready = 1'b1;
        #1 chk("fullpop_head", 32'(cdata), 32'(sb.pop_front()));
        mcnt = 3;
        tick(); we = 1'b0;
        rd_chk("fullpop_status", 8'hF4, 32'h1C);
        drain();
        rd_chk("ovf_after_drain", 8'hF4, 32'h05);
        wr(8'hF4, 32'h0);
        rd_chk("status_w0_keeps", 8'hF4, 32'h05);
        wr(8'hF4, 32'h4);
        rd_chk("status_clear", 8'hF4, 32'h01);

        // Cycle counter load, wrap, freeze
        wr(8'hF8, 32'hFFFFFFFE);
        rd_chk("cycle_load", 8'hF8, 32'hFFFFFFFE);
        tick();
        chk("cycle_max", rdata, 32'hFFFFFFFF);
        tick();
        chk("cycle_wrap", rdata, 32'h0);
        clk_enable = 1'b0;
        waddr = 8'hF0; wdata = 32'h77; we = 1'b1;
        tick(); tick(); tick();
        we = 1'b0;
        chk("cycle_frozen", rdata, 32'h0);
        rd_chk("fifo_frozen", 8'hF4, 32'h01);
        clk_enable = 1'b1;
        raddr = 8'hF8;
        tick();
        chk("cycle_resume", rdata, 32'h1);

        // ID register is read-only
        rd_chk("id_read", 8'hFC, 32'h4D495053);
        wr(8'hFC, 32'h0);
        rd_chk("id_after_write", 8'hFC, 32'h4D495053);

        // Asynchronous reset mid-cycle discards queued bytes
        cready = 1'b0;
        push(8'h61); push(8'h62);
        chk("pre_reset_valid", 32'(cvalid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(cvalid), 32'd0);
        chk("async_rst_data", 32'(cdata), 32'd0);
        rd_chk("async_rst_cycle", 8'hF8, 32'h0);
        rd_chk("ram_kept", 8'h10, 32'h12345678);
        rd_chk("async_rst_status", 8'hF4, 32'h01);
        sb.delete();
        mcnt = 0;
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid", 32'(cvalid), 32'd0);
        rd_chk("post_rst_cycle", 8'hF8, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
